// File: rtl/gate_input_debouncer.sv
// Per-channel 2-flop synchroniser + stable-count debounce filter with registered edge pulses.
// Latency: 2 + STABLE_CYCLES edges from raw change to db_out/pulse; no backpressure (free-running).
module gate_input_debouncer #(
  parameter int N_CH          = 2,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse
);

  typedef enum logic [1:0] {
    LOW_STABLE,
    CHK_HIGH,
    HIGH_STABLE,
    CHK_LOW
  } state_t;

  // cnt already includes the cycle that entered the CHK state, so the
  // STABLE_CYCLES-th consecutive differing sample is seen with cnt == STABLE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit               FAST     = (STABLE_CYCLES == 1);

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        LOW_STABLE: begin
          cnt_d = '0;
          if (s2[g]) begin
            if (FAST) begin
              state_d = HIGH_STABLE;
              db_d    = 1'b1;
              rise_d  = 1'b1;
            end else begin
              state_d = CHK_HIGH;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHK_HIGH: begin
          if (!s2[g]) begin
            state_d = LOW_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HIGH_STABLE;
            db_d    = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HIGH_STABLE: begin
          cnt_d = '0;
          if (!s2[g]) begin
            if (FAST) begin
              state_d = LOW_STABLE;
              db_d    = 1'b0;
              fall_d  = 1'b1;
            end else begin
              state_d = CHK_LOW;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHK_LOW: begin
          if (s2[g]) begin
            state_d = HIGH_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = LOW_STABLE;
            db_d    = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
          db_d    = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= LOW_STABLE;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign db_out[g]     = db_q;
    assign rise_pulse[g] = rise_q;
    assign fall_pulse[g] = fall_q;
  end

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Bench for gate_input_debouncer: directed vector table, async-reset sequence,
// and randomized levels checked against a sample-window reference model.
module tb_gate_input_debouncer;

  localparam int S  = 4;
  localparam int NC = 2;

  logic          clk;
  logic          rst;
  logic [NC-1:0] raw_in;
  logic [NC-1:0] db_out;
  logic [NC-1:0] rise_pulse;
  logic [NC-1:0] fall_pulse;

  int checks = 0;
  int errors = 0;

  gate_input_debouncer #(.N_CH(NC), .STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .db_out    (db_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: history of raw samples (index 0 = newest). The filter
  // at an edge sees the raw value sampled two edges earlier; db flips when
  // the last S filter-visible samples all differ from the current db.
  logic [NC-1:0] hist[$];
  logic [NC-1:0] m_db, m_rise, m_fall;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < S + 2; i++) hist.push_back('0);
    m_db   = '0;
    m_rise = '0;
    m_fall = '0;
  endfunction

  function automatic void model_edge(input logic [NC-1:0] r);
    logic all_diff;
    hist.push_front(r);
    void'(hist.pop_back());
    m_rise = '0;
    m_fall = '0;
    for (int ch = 0; ch < NC; ch++) begin
      all_diff = 1'b1;
      for (int j = 2; j < S + 2; j++)
        if (hist[j][ch] == m_db[ch]) all_diff = 1'b0;
      if (all_diff) begin
        if (m_db[ch]) m_fall[ch] = 1'b1;
        else          m_rise[ch] = 1'b1;
        m_db[ch] = ~m_db[ch];
      end
    end
  endfunction

  task automatic check(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Drive inputs, take one edge, update model, then settle away from the edge.
  task automatic tick(input logic r, input logic [NC-1:0] v);
    rst    = r;
    raw_in = v;
    @(posedge clk);
    if (r) model_reset();
    else   model_edge(v);
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic [NC-1:0] raw;
    logic [NC-1:0] db;
    logic [NC-1:0] rise;
    logic [NC-1:0] fall;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [NC-1:0] raw, input logic [NC-1:0] db,
                     input logic [NC-1:0] rise, input logic [NC-1:0] fall, input int n);
    vec_t v;
    v.rst = r; v.raw = raw; v.db = db; v.rise = rise; v.fall = fall;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    logic [NC-1:0] cur;
    logic          r;

    rst    = 1'b1;
    raw_in = '0;
    model_reset();

    // reset, steady, and inputs high during reset
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 3);
    add(1, 2'b11, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    // clean press on ch0: rise 5 edges after first 1 sample
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(0, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    // release ch0
    add(0, 2'b00, 2'b01, 2'b00, 2'b00, 5);
    add(0, 2'b00, 2'b00, 2'b00, 2'b01, 1);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    // bounce settling low
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 7);
    // bounce settling high
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(0, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    add(0, 2'b00, 2'b01, 2'b00, 2'b00, 5);
    add(0, 2'b00, 2'b00, 2'b00, 2'b01, 1);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    // both channels together, up then down
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b11, 2'b11, 2'b11, 2'b00, 1);
    add(0, 2'b11, 2'b11, 2'b00, 2'b00, 1);
    add(0, 2'b00, 2'b11, 2'b00, 2'b00, 5);
    add(0, 2'b00, 2'b00, 2'b00, 2'b11, 1);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    // ch1 alone
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b10, 2'b10, 2'b10, 2'b00, 1);
    add(0, 2'b10, 2'b10, 2'b00, 2'b00, 1);

    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].raw);
      check($sformatf("vec%0d_db", i),   db_out,     vecs[i].db);
      check($sformatf("vec%0d_rise", i), rise_pulse, vecs[i].rise);
      check($sformatf("vec%0d_fall", i), fall_pulse, vecs[i].fall);
      check($sformatf("vec%0d_and", i), {1'b0, db_out[0] & db_out[1]},
            {1'b0, vecs[i].db[0] & vecs[i].db[1]});
    end

    // Async reset mid-count while ch1 is still high: ch0 counting 3 samples.
    for (int i = 0; i < 5; i++) tick(1'b0, 2'b01);
    check("pre_async_db", db_out, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("async_db",   db_out,     2'b00);
    check("async_rise", rise_pulse, 2'b00);
    check("async_fall", fall_pulse, 2'b00);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 2'b01);
      check($sformatf("post_rst%0d_db", i),   db_out,     (i == 5) ? 2'b01 : 2'b00);
      check($sformatf("post_rst%0d_rise", i), rise_pulse, (i == 5) ? 2'b01 : 2'b00);
    end

    // Randomized levels with bursts of bounce, occasional reset.
    cur = 2'b01;
    for (int n = 0; n < 1500; n++) begin
      for (int ch = 0; ch < NC; ch++)
        if ($urandom_range(0, 5) == 0) cur[ch] = ~cur[ch];
      r = ($urandom_range(0, 199) == 0);
      tick(r, cur);
      check("rand_db",   db_out,     m_db);
      check("rand_rise", rise_pulse, m_rise);
      check("rand_fall", fall_pulse, m_fall);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
